// File: rtl/jtframe_neptuno_joydb.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_neptuno_joydb
// Description : NEPTUNO+ DB9/JAMMA serial joystick scanner. Drives the
//               adapter's PISO chain and returns two active-high player words.
//               Optional: JTFRAME_JOYDB_DEBOUNCE_EN (two-scan agreement).
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_neptuno_joydb #(
    parameter int CLKDIV    = 8,
    parameter int FRAME_GAP = 16,
    parameter int JOYW      = 12
) (
    input  logic            clk,
    input  logic            rst,
    output logic            joy_clk,
    output logic            joy_load,
    input  logic            joy_data,
    output logic [JOYW-1:0] joy1,
    output logic [JOYW-1:0] joy2,
    output logic            frame_done,
    output logic            busy
);

    localparam int c_NBITS = 2 * JOYW;
    localparam int c_DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int c_GAP_W = $clog2(FRAME_GAP + 1);
    localparam int c_BIT_W = $clog2(c_NBITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [1:0]         r_sync;
    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_GAP_W-1:0] r_gap;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_BIT_W-1:0] w_bit_nxt;
    logic [c_NBITS-1:0] r_sr;
    logic [c_NBITS-1:0] w_sr_nxt;
    logic               w_jclk_nxt;
    logic               w_load_nxt;
    logic               w_last;

    assign w_tick = (r_div == c_DIV_W'(CLKDIV - 1));

    // The chain idles released (ones), so the synchronizer resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_div  <= '0;
        end else begin
            r_sync <= {r_sync[0], joy_data};
            r_div  <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_bit_nxt   = r_bit;
        w_sr_nxt    = r_sr;
        w_jclk_nxt  = joy_clk;
        w_load_nxt  = joy_load;
        w_last      = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_jclk_nxt = 1'b1;
                    w_load_nxt = 1'b1;
                    if (r_gap == c_GAP_W'(FRAME_GAP)) begin
                        w_state_nxt = ST_LOAD;
                        w_load_nxt  = 1'b0;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                ST_LOAD: begin
                    w_load_nxt  = 1'b1;
                    w_jclk_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Sample while the clock is low; the rising edge then
                    // advances the chain to the next bit.
                    if (!joy_clk) begin
                        w_sr_nxt   = {r_sr[c_NBITS-2:0], r_sync[1]};
                        w_jclk_nxt = 1'b1;
                        w_bit_nxt  = r_bit + 1'b1;
                        if (r_bit == c_BIT_W'(c_NBITS - 1)) begin
                            w_last      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_jclk_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef JTFRAME_JOYDB_DEBOUNCE_EN
    logic [c_NBITS-1:0] r_prev;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gap      <= '0;
            r_bit      <= '0;
            r_sr       <= '1;
            joy_clk    <= 1'b1;
            joy_load   <= 1'b1;
            joy1       <= '0;
            joy2       <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
`ifdef JTFRAME_JOYDB_DEBOUNCE_EN
            r_prev     <= '1;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_gap      <= w_gap_nxt;
            r_bit      <= w_bit_nxt;
            r_sr       <= w_sr_nxt;
            joy_clk    <= w_jclk_nxt;
            joy_load   <= w_load_nxt;
            frame_done <= w_last;
            busy       <= (w_state_nxt != ST_IDLE);
            if (w_last) begin
`ifdef JTFRAME_JOYDB_DEBOUNCE_EN
                if (w_sr_nxt == r_prev) begin
                    joy1 <= ~w_sr_nxt[c_NBITS-1:JOYW];
                    joy2 <= ~w_sr_nxt[JOYW-1:0];
                end
                r_prev <= w_sr_nxt;
`else
                joy1 <= ~w_sr_nxt[c_NBITS-1:JOYW];
                joy2 <= ~w_sr_nxt[JOYW-1:0];
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_neptuno_joydb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtframe_neptuno_joydb
// Description : Self-checking bench: PISO chain model plus a scan-level
//               reference model of the player outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_neptuno_joydb;

    localparam int CLKDIV    = 4;
    localparam int FRAME_GAP = 8;
    localparam int JOYW      = 12;
    localparam int NBITS     = 2 * JOYW;
    localparam int PERIOD    = CLKDIV * (FRAME_GAP + 1 + 2 * NBITS);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            joy_clk, joy_load, joy_data, frame_done, busy;
    logic [JOYW-1:0] joy1, joy2;

    logic [NBITS-1:0] pattern = '1;
    logic [NBITS-1:0] chain   = '1;
    logic             glitch  = 1'b0;
    int               ph      = 0;
    int               cyc     = 0;
    logic             prev_jclk = 1'b1;
    int               rises = 0, rises_last = 0, lowc = 0, lowc_last = 0;

    int n_assert = 0;
    int n_fail   = 0;
    int ref_cyc  = 0;

    logic [JOYW-1:0]  m_j1, m_j2;
    logic [NBITS-1:0] m_prev;

    jtframe_neptuno_joydb #(
        .CLKDIV    (CLKDIV),
        .FRAME_GAP (FRAME_GAP),
        .JOYW      (JOYW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .joy1       (joy1),
        .joy2       (joy2),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Glitches land only on the two edges just before each sampling tick.
    assign joy_data = chain[NBITS-1] ^ (glitch && (ph >= CLKDIV - 2));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ph  <= rst ? 0 : ((ph == CLKDIV - 1) ? 0 : ph + 1);
    end

    always @(posedge clk) begin
        if (!joy_load)
            chain <= pattern;
        else if (joy_clk && !prev_jclk)
            chain <= {chain[NBITS-2:0], 1'b1};
    end

    always @(posedge clk) begin
        if (rst) begin
            prev_jclk <= 1'b1;
            rises     <= 0;
            lowc      <= 0;
        end else begin
            prev_jclk <= joy_clk;
            if (frame_done) begin
                rises_last <= rises + ((joy_clk && !prev_jclk) ? 1 : 0);
                lowc_last  <= lowc + (!joy_load ? 1 : 0);
                rises      <= 0;
                lowc       <= 0;
            end else begin
                rises <= rises + ((joy_clk && !prev_jclk) ? 1 : 0);
                lowc  <= lowc + (!joy_load ? 1 : 0);
            end
        end
    end

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_j1   = '0;
        m_j2   = '0;
        m_prev = '1;
    endtask

    // A scan of word w (active-low chain image) gives player words ~w.
    task automatic model_scan(input logic [NBITS-1:0] w);
`ifdef JTFRAME_JOYDB_DEBOUNCE_EN
        if (w == m_prev) begin
            m_j1 = ~w[NBITS-1:JOYW];
            m_j2 = ~w[JOYW-1:0];
        end
        m_prev = w;
`else
        m_j1 = ~w[NBITS-1:JOYW];
        m_j2 = ~w[JOYW-1:0];
`endif
    endtask

    task automatic wait_done(output bit found, output bit held);
        logic [JOYW-1:0] h1, h2;
        h1    = joy1;
        h2    = joy2;
        found = 1'b0;
        held  = 1'b1;
        for (int i = 0; i < PERIOD + 8 && !found; i++) begin
            @(posedge clk);
            #1;
            if (frame_done)
                found = 1'b1;
            else if (joy1 !== h1 || joy2 !== h2)
                held = 1'b0;
        end
    endtask

    task automatic do_scan(input logic [NBITS-1:0] w, input string tag);
        bit found, held;
        pattern = w;
        wait_done(found, held);
        model_scan(w);
        check(tag, "done_seen", {31'd0, found}, 32'd1);
        check(tag, "spacing", cyc - ref_cyc, PERIOD);
        ref_cyc = cyc;
        check(tag, "joy1", {20'd0, joy1}, {20'd0, m_j1});
        check(tag, "joy2", {20'd0, joy2}, {20'd0, m_j2});
        check(tag, "held", {31'd0, held}, 32'd1);
        check(tag, "busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check(tag, "done_width", {31'd0, frame_done}, 32'd0);
        check(tag, "clk_rises", rises_last, NBITS);
        check(tag, "load_low", lowc_last, CLKDIV);
    endtask

    initial begin
        bit               found;
        logic             lastj;
        int               r;
        int               k;
        logic [NBITS-1:0] w;

        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset", "joy1", {20'd0, joy1}, 32'd0);
        check("reset", "joy2", {20'd0, joy2}, 32'd0);
        check("reset", "joy_clk", {31'd0, joy_clk}, 32'd1);
        check("reset", "joy_load", {31'd0, joy_load}, 32'd1);
        check("reset", "frame_done", {31'd0, frame_done}, 32'd0);
        check("reset", "busy", {31'd0, busy}, 32'd0);
        rst     = 1'b0;
        ref_cyc = cyc;

        found = 1'b0;
        for (int i = 0; i < 4 * PERIOD && !found; i++) begin
            @(posedge clk);
            #1;
            if (!joy_load) found = 1'b1;
        end
        check("first_load", "found", {31'd0, found}, 32'd1);
        check("first_load", "cycles", cyc - ref_cyc, CLKDIV * (FRAME_GAP + 1));
        check("first_load", "busy", {31'd0, busy}, 32'd1);

        do_scan('1, "idle");
        do_scan('1, "idle2");
        do_scan(24'h5A3C96, "pattern");
        do_scan(24'h5A3C96, "pattern2");
        do_scan(24'h7FFFFF, "bitorder");
        do_scan(24'h7FFFFF, "bitorder2");
        do_scan(24'h5A3C96, "deb_base");
        do_scan(24'h5A3C96, "deb_base2");
        do_scan(24'h123456, "deb_single");
        do_scan(24'h5A3C96, "deb_back");
        do_scan(24'hABCDEF, "deb_hold1");
        do_scan(24'hABCDEF, "deb_hold2");

        glitch = 1'b1;
        repeat (6) begin
            w = NBITS'($urandom());
            k = $urandom_range(1, 2);
            repeat (k) do_scan(w, "sync");
        end
        glitch = 1'b0;

        do_scan('0, "allpress");
        do_scan('0, "allpress2");

        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            @(posedge clk);
            #1;
            if (!joy_load) found = 1'b1;
        end
        check("midrst", "load_seen", {31'd0, found}, 32'd1);
        r     = 0;
        lastj = joy_clk;
        for (int i = 0; i < PERIOD && r < 10; i++) begin
            @(posedge clk);
            #1;
            if (joy_clk && !lastj) r++;
            lastj = joy_clk;
        end
        check("midrst", "bits_before", r, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("midrst", "joy1", {20'd0, joy1}, 32'd0);
        check("midrst", "joy2", {20'd0, joy2}, 32'd0);
        check("midrst", "joy_clk", {31'd0, joy_clk}, 32'd1);
        check("midrst", "joy_load", {31'd0, joy_load}, 32'd1);
        check("midrst", "busy", {31'd0, busy}, 32'd0);
        check("midrst", "frame_done", {31'd0, frame_done}, 32'd0);
        rst     = 1'b0;
        ref_cyc = cyc;
        do_scan('0, "after_rst");
        do_scan('0, "after_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
